dpram_clr: RTL and testbench
============================

DPRAM_CLR -- requirements
Module: dpram_clr

Interface
REQ-001 The module SHALL have parameter data_width_g, default 8, meaning word width in bits; it must be a multiple of 8.
REQ-002 The module SHALL have parameter addr_width_g, default 14, meaning address width; depth is 2**addr_width_g words.
REQ-003 The module SHALL have parameter out_reg_g, default 0, meaning read latency: 0 gives 1 cycle, 1 adds an output register for 2 cycles.
REQ-004 The module SHALL have parameter rdw_mode_g, default 0, meaning same-port write behaviour: 0 leaves q unchanged, 1 writes through.
REQ-005 The module SHALL have parameter fill_g, default all zeros, data_width_g bits, meaning the clear value.
REQ-006 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-007 The module SHALL have these ports (NB = data_width_g/8):
- clock  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- enable_a  in  1  port A access strobe
- wren_a  in  1  port A write (1) / read (0)
- be_a  in  NB  port A byte enables, active high
- address_a  in  addr_width_g  port A address
- data_a  in  data_width_g  port A write data
- q_a  out  data_width_g  port A read data
- valid_a  out  1  q_a updated this cycle
- enable_b, wren_b, be_b, address_b, data_b, q_b, valid_b  as port A
- clear_req  in  1  start full-array clear (level sampled)
- clear_busy  out  1  clear sequence in progress
- clear_done  out  1  one-cycle pulse at end of clear

Function
REQ-008 Port A and port B SHALL be fully independent read/write ports on one shared array, both clocked by clock.
REQ-009 A write (enable & wren) SHALL update only bytes whose be bit is 1; bytes with be=0 keep their old value.
REQ-010 A read (enable & !wren) SHALL present the word at q and pulse valid exactly 1 cycle later (out_reg_g=0) or 2 cycles later (out_reg_g=1).
REQ-011 When valid is low, q SHALL hold its last value.
REQ-012 A write with rdw_mode_g=0 SHALL leave q unchanged and valid low.
REQ-013 A write with rdw_mode_g=1 SHALL present the merged post-write word at q with valid, at the same latency as a read.
REQ-014 A cross-port read of an address written in the same cycle SHALL return the old (pre-write) data.
REQ-015 On simultaneous writes to the same address, port A SHALL win on every byte both ports enable; bytes enabled by only one port take that port's data.
REQ-016 The clear FSM SHALL have states IDLE and CLEAR.
REQ-017 In IDLE, clear_req=1 SHALL move the FSM to CLEAR on the next edge, with clear_busy=1 and the address counter at 0.
REQ-018 In CLEAR, each cycle SHALL write fill_g (all bytes) to the counter address, then increment the counter.
REQ-019 After the write of address 2**addr_width_g-1, the FSM SHALL return to IDLE, clear_busy=0, and clear_done=1 for exactly one cycle; a clear lasts 2**addr_width_g cycles.
REQ-020 clear_req while clear_busy=1 SHALL be ignored; a level still high in IDLE after done SHALL start a new clear.
REQ-021 While clear_busy=1, port accesses SHALL be discarded: no write, no valid.
REQ-022 Reads already in the out_reg_g pipeline when a clear starts SHALL still complete.
REQ-023 The address counter SHALL wrap only through the FSM exit; no counter overflow is visible externally.

Reset
REQ-024 On reset_n=0, outputs SHALL immediately go to q_a=0, q_b=0, valid_a=0, valid_b=0, clear_busy=0, clear_done=0; the FSM goes to IDLE, the counter to 0, and read pipelines clear.
REQ-025 Array contents SHALL NOT be affected by reset; a clear interrupted by reset leaves the array partially cleared and does not resume.
REQ-026 Reset release SHALL be synchronous to clock; the first access is accepted on the first edge with reset_n=1.

Verification
REQ-027 The bench SHALL cover: aw=4, dw=16, out_reg_g=0; A writes 0xBEEF to addr 3 with be=11, then B reads addr 3 -> q_b=0xBEEF, valid_b pulses 1 cycle after the read.
REQ-028 The bench SHALL cover: A writes 0x1234 to addr 5 with be=01 over 0xFFFF -> a read gives 0xFF34; with out_reg_g=1, valid comes 2 cycles after the read.
REQ-029 The bench SHALL cover: same cycle, A writes 0xAAAA and B writes 0x5555 to addr 7 with be=11 -> a read gives 0xAAAA; with B be=10 and A be=01 -> 0x55AA.
REQ-030 The bench SHALL cover: addr 2=0x0001; same cycle, A writes 0x0002 to addr 2 and B reads addr 2 -> q_b=0x0001; with rdw_mode_g=1, q_a=0x0002 and valid_a=1.
REQ-031 The bench SHALL cover: fill_g=0xA5A5, clear_req pulsed -> clear_busy high for 16 cycles, clear_done pulses once, all 16 addresses read 0xA5A5, and port writes during busy are lost.
REQ-032 The bench SHALL cover: reset_n=0 asserted at cycle 5 of a clear -> busy=0 and done=0 immediately; addrs 0-4 read fill_g and addrs 5-15 keep their old data.

Source files
------------

// File: rtl/dpram_clr_if.sv
// Bus bundle for dpram_clr: two independent byte-enabled access ports plus the clear handshake.
interface dpram_clr_if #(
    parameter int unsigned data_width_g = 8,
    parameter int unsigned addr_width_g = 14
);
    localparam int unsigned NB = data_width_g / 8;

    logic                    enable_a;
    logic                    wren_a;
    logic [NB-1:0]           be_a;
    logic [addr_width_g-1:0] address_a;
    logic [data_width_g-1:0] data_a;
    logic [data_width_g-1:0] q_a;
    logic                    valid_a;

    logic                    enable_b;
    logic                    wren_b;
    logic [NB-1:0]           be_b;
    logic [addr_width_g-1:0] address_b;
    logic [data_width_g-1:0] data_b;
    logic [data_width_g-1:0] q_b;
    logic                    valid_b;

    logic                    clear_req;
    logic                    clear_busy;
    logic                    clear_done;

    modport master (
        output enable_a, wren_a, be_a, address_a, data_a,
        input  q_a, valid_a,
        output enable_b, wren_b, be_b, address_b, data_b,
        input  q_b, valid_b,
        output clear_req,
        input  clear_busy, clear_done
    );

    modport slave (
        input  enable_a, wren_a, be_a, address_a, data_a,
        output q_a, valid_a,
        input  enable_b, wren_b, be_b, address_b, data_b,
        output q_b, valid_b,
        input  clear_req,
        output clear_busy, clear_done
    );
endinterface

// File: rtl/dpram_clr.sv
// True dual-port RAM with byte enables, optional output register,
// selectable write-through, and a sequential whole-array clear engine.
module dpram_clr #(
    parameter int unsigned data_width_g = 8,
    parameter int unsigned addr_width_g = 14,
    parameter int unsigned out_reg_g    = 0,
    parameter int unsigned rdw_mode_g   = 0,
    parameter logic [data_width_g-1:0] fill_g = '0
) (
    input  logic       clock,
    input  logic       reset_n,
    dpram_clr_if.slave bus
);
    localparam int unsigned NB    = data_width_g / 8;
    localparam int unsigned DEPTH = 2 ** addr_width_g;
    localparam logic [addr_width_g-1:0] LAST_ADDR = '1;
    localparam logic                    WR_THRU   = (rdw_mode_g != 0);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [data_width_g-1:0] mem_q [DEPTH];

    logic [0:0]              state_q, state_d;
    logic [addr_width_g-1:0] ctr_q, ctr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    clr_we_c;

    logic                    rd_a_c, wr_a_c, rd_b_c, wr_b_c, same_addr_c;
    logic                    out_a_c, out_b_c;
    logic [data_width_g-1:0] old_a_c, old_b_c, merged_a_c, merged_b_c;
    logic [data_width_g-1:0] sel_a_c, sel_b_c;

    logic                    s1_valid_a_q, s1_valid_b_q;
    logic [data_width_g-1:0] s1_data_a_q, s1_data_b_q;

    // Port accesses are dropped while the clear engine owns the array.
    assign rd_a_c      = bus.enable_a & ~bus.wren_a & ~busy_q;
    assign wr_a_c      = bus.enable_a &  bus.wren_a & ~busy_q;
    assign rd_b_c      = bus.enable_b & ~bus.wren_b & ~busy_q;
    assign wr_b_c      = bus.enable_b &  bus.wren_b & ~busy_q;
    assign same_addr_c = (bus.address_a == bus.address_b);

    assign old_a_c = mem_q[bus.address_a];
    assign old_b_c = mem_q[bus.address_b];

    // Post-write word seen by each port; port A owns any byte lane both ports write.
    always_comb begin
        merged_a_c = old_a_c;
        merged_b_c = old_b_c;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_a_c && bus.be_a[i]) begin
                merged_a_c[i*8 +: 8] = bus.data_a[i*8 +: 8];
            end else if (wr_b_c && same_addr_c && bus.be_b[i]) begin
                merged_a_c[i*8 +: 8] = bus.data_b[i*8 +: 8];
            end
            if (wr_a_c && same_addr_c && bus.be_a[i]) begin
                merged_b_c[i*8 +: 8] = bus.data_a[i*8 +: 8];
            end else if (wr_b_c && bus.be_b[i]) begin
                merged_b_c[i*8 +: 8] = bus.data_b[i*8 +: 8];
            end
        end
    end

    assign out_a_c = rd_a_c | (wr_a_c & WR_THRU);
    assign out_b_c = rd_b_c | (wr_b_c & WR_THRU);
    assign sel_a_c = rd_a_c ? old_a_c : merged_a_c;
    assign sel_b_c = rd_b_c ? old_b_c : merged_b_c;

    // Array update: clear word, then B lanes, then A lanes so A overrides on overlap.
    always_ff @(posedge clock) begin
        if (clr_we_c) begin
            mem_q[ctr_q] <= fill_g;
        end
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_b_c && bus.be_b[i]) begin
                mem_q[bus.address_b][i*8 +: 8] <= bus.data_b[i*8 +: 8];
            end
        end
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_a_c && bus.be_a[i]) begin
                mem_q[bus.address_a][i*8 +: 8] <= bus.data_a[i*8 +: 8];
            end
        end
    end

    // Clear engine next-state: walk every address once, then pulse done.
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clr_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    ctr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                clr_we_c = 1'b1;
                if (ctr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    ctr_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ctr_d = ctr_q + addr_width_g'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ctr_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Clear engine state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;

    // First read stage; data holds whenever no result is produced.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_a_q <= 1'b0;
            s1_valid_b_q <= 1'b0;
            s1_data_a_q  <= '0;
            s1_data_b_q  <= '0;
        end else begin
            s1_valid_a_q <= out_a_c;
            s1_valid_b_q <= out_b_c;
            if (out_a_c) begin
                s1_data_a_q <= sel_a_c;
            end
            if (out_b_c) begin
                s1_data_b_q <= sel_b_c;
            end
        end
    end

    if (out_reg_g != 0) begin : g_out_reg
        logic                    s2_valid_a_q, s2_valid_b_q;
        logic [data_width_g-1:0] s2_data_a_q, s2_data_b_q;

        // Optional second read stage; in-flight results drain even if a clear starts.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid_a_q <= 1'b0;
                s2_valid_b_q <= 1'b0;
                s2_data_a_q  <= '0;
                s2_data_b_q  <= '0;
            end else begin
                s2_valid_a_q <= s1_valid_a_q;
                s2_valid_b_q <= s1_valid_b_q;
                if (s1_valid_a_q) begin
                    s2_data_a_q <= s1_data_a_q;
                end
                if (s1_valid_b_q) begin
                    s2_data_b_q <= s1_data_b_q;
                end
            end
        end

        assign bus.q_a     = s2_data_a_q;
        assign bus.valid_a = s2_valid_a_q;
        assign bus.q_b     = s2_data_b_q;
        assign bus.valid_b = s2_valid_b_q;
    end else begin : g_no_out_reg
        assign bus.q_a     = s1_data_a_q;
        assign bus.valid_a = s1_valid_a_q;
        assign bus.q_b     = s1_data_b_q;
        assign bus.valid_b = s1_valid_b_q;
    end

endmodule

// File: tb/tb_dpram_clr.sv
// Bench for dpram_clr: two instances (1-cycle/no write-through and 2-cycle/write-through)
// driven by identical stimulus and checked against an event-scheduled reference model.
module tb_dpram_clr;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] FILL  = 16'hA5A5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        en_a, wr_a, en_b, wr_b, clr;
    logic [1:0]  be_a, be_b;
    logic [3:0]  ad_a, ad_b;
    logic [15:0] d_a, d_b;

    dpram_clr_if #(.data_width_g(DW), .addr_width_g(AW)) if0 ();
    dpram_clr_if #(.data_width_g(DW), .addr_width_g(AW)) if1 ();

    assign if0.enable_a = en_a;  assign if1.enable_a = en_a;
    assign if0.wren_a   = wr_a;  assign if1.wren_a   = wr_a;
    assign if0.be_a     = be_a;  assign if1.be_a     = be_a;
    assign if0.address_a = ad_a; assign if1.address_a = ad_a;
    assign if0.data_a   = d_a;   assign if1.data_a   = d_a;
    assign if0.enable_b = en_b;  assign if1.enable_b = en_b;
    assign if0.wren_b   = wr_b;  assign if1.wren_b   = wr_b;
    assign if0.be_b     = be_b;  assign if1.be_b     = be_b;
    assign if0.address_b = ad_b; assign if1.address_b = ad_b;
    assign if0.data_b   = d_b;   assign if1.data_b   = d_b;
    assign if0.clear_req = clr;  assign if1.clear_req = clr;

    dpram_clr #(.data_width_g(DW), .addr_width_g(AW), .out_reg_g(0), .rdw_mode_g(0), .fill_g(FILL))
        dut0 (.clock(clk), .reset_n(rst_n), .bus(if0));
    dpram_clr #(.data_width_g(DW), .addr_width_g(AW), .out_reg_g(1), .rdw_mode_g(1), .fill_g(FILL))
        dut1 (.clock(clk), .reset_n(rst_n), .bus(if1));

    // Reference model: array contents, clear sequencing, and results scheduled by due edge.
    // Result slots: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
    logic [15:0] mem [DEPTH];
    bit          m_busy, m_done;
    int          m_ctr;
    int          edge_n;
    bit          sv [4][8];
    logic [15:0] sd [4][8];
    logic [15:0] eq [4];
    bit          ev [4];

    int total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_ctr  = 0;
        for (int k = 0; k < 4; k++) begin
            eq[k] = '0;
            ev[k] = 1'b0;
            for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
        end
    endtask

    task automatic sched(input int k, input int lat, input logic [15:0] d);
        sv[k][(edge_n + lat - 1) % 8] = 1'b1;
        sd[k][(edge_n + lat - 1) % 8] = d;
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic model_edge();
        bit          acc_a, acc_b;
        logic [15:0] old_a, old_b, ma, mb;
        edge_n++;
        if (rst_n) begin
            acc_a = en_a && !m_busy;
            acc_b = en_b && !m_busy;
            old_a = mem[ad_a];
            old_b = mem[ad_b];
            ma    = lane_mask(be_a);
            mb    = lane_mask(be_b);
            if (acc_b && wr_b) mem[ad_b] = (mem[ad_b] & ~mb) | (d_b & mb);
            if (acc_a && wr_a) mem[ad_a] = (mem[ad_a] & ~ma) | (d_a & ma);
            if (acc_a && !wr_a) begin sched(0, 1, old_a); sched(2, 2, old_a); end
            if (acc_b && !wr_b) begin sched(1, 1, old_b); sched(3, 2, old_b); end
            if (acc_a && wr_a) sched(2, 2, mem[ad_a]);
            if (acc_b && wr_b) sched(3, 2, mem[ad_b]);
            m_done = 1'b0;
            if (m_busy) begin
                mem[m_ctr] = FILL;
                m_ctr++;
                if (m_ctr == int'(DEPTH)) begin
                    m_busy = 1'b0;
                    m_ctr  = 0;
                    m_done = 1'b1;
                end
            end else if (clr) begin
                m_busy = 1'b1;
                m_ctr  = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (rst_n && sv[k][edge_n % 8]) begin
                ev[k] = 1'b1;
                eq[k] = sd[k][edge_n % 8];
            end else begin
                ev[k] = 1'b0;
            end
            sv[k][edge_n % 8] = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("q_a0", 32'(if0.q_a), 32'(eq[0]));
        chk("v_a0", 32'(if0.valid_a), 32'(ev[0]));
        chk("q_b0", 32'(if0.q_b), 32'(eq[1]));
        chk("v_b0", 32'(if0.valid_b), 32'(ev[1]));
        chk("q_a1", 32'(if1.q_a), 32'(eq[2]));
        chk("v_a1", 32'(if1.valid_a), 32'(ev[2]));
        chk("q_b1", 32'(if1.q_b), 32'(eq[3]));
        chk("v_b1", 32'(if1.valid_b), 32'(ev[3]));
        chk("busy0", 32'(if0.clear_busy), 32'(m_busy));
        chk("done0", 32'(if0.clear_done), 32'(m_done));
        chk("busy1", 32'(if1.clear_busy), 32'(m_busy));
        chk("done1", 32'(if1.clear_done), 32'(m_done));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        en_a = 1'b0; wr_a = 1'b0; be_a = 2'b00; ad_a = '0; d_a = '0;
        en_b = 1'b0; wr_b = 1'b0; be_b = 2'b00; ad_b = '0; d_b = '0;
        clr  = 1'b0;
    endtask

    task automatic wr_port_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        en_a = 1'b1; wr_a = 1'b1; ad_a = a; d_a = d; be_a = be;
        step();
        en_a = 1'b0; wr_a = 1'b0;
    endtask

    task automatic rd_port_a(input logic [3:0] a);
        en_a = 1'b1; wr_a = 1'b0; ad_a = a;
        step();
        en_a = 1'b0;
    endtask

    task automatic rd_port_b(input logic [3:0] a);
        en_b = 1'b1; wr_b = 1'b0; ad_b = a;
        step();
        en_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt;
        total  = 0;
        bad    = 0;
        edge_n = 0;
        idle_inputs();
        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        #1 compare_all();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Full clear with writes attempted while busy
        clr = 1'b1;
        step();
        clr = 1'b0;
        busy_cnt = int'(if0.clear_busy);
        done_cnt = 0;
        en_a = 1'b1; wr_a = 1'b1; ad_a = 4'd1; d_a = 16'h1111; be_a = 2'b11;
        en_b = 1'b1; wr_b = 1'b0; ad_b = 4'd2;
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 3) begin
                idle_inputs();
                en_b = 1'b1; wr_b = 1'b1; ad_b = 4'd9; d_b = 16'h2222; be_b = 2'b11;
            end
            if (i == 6) idle_inputs();
            busy_cnt += int'(if0.clear_busy);
            done_cnt += int'(if0.clear_done);
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("clr_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_port_a(4'(i));
            chk("clr_fill", 32'(if0.q_a), 32'(FILL));
        end
        step();

        // A writes, B reads back
        wr_port_a(4'd3, 16'hBEEF, 2'b11);
        rd_port_b(4'd3);
        chk("beef_q", 32'(if0.q_b), 32'h0000BEEF);
        chk("beef_v", 32'(if0.valid_b), 32'd1);
        step();
        chk("beef_hold_v", 32'(if0.valid_b), 32'd0);
        chk("beef_hold_q", 32'(if0.q_b), 32'h0000BEEF);
        chk("beef_q_lat2", 32'(if1.q_b), 32'h0000BEEF);

        // Byte-enable merge and two-cycle latency
        wr_port_a(4'd5, 16'hFFFF, 2'b11);
        wr_port_a(4'd5, 16'h1234, 2'b01);
        step();
        rd_port_a(4'd5);
        chk("be_q", 32'(if0.q_a), 32'h0000FF34);
        chk("be_v_lat2_early", 32'(if1.valid_a), 32'd0);
        step();
        chk("be_v_lat2", 32'(if1.valid_a), 32'd1);
        chk("be_q_lat2", 32'(if1.q_a), 32'h0000FF34);

        // Simultaneous writes to one address
        en_a = 1'b1; wr_a = 1'b1; ad_a = 4'd7; d_a = 16'hAAAA; be_a = 2'b11;
        en_b = 1'b1; wr_b = 1'b1; ad_b = 4'd7; d_b = 16'h5555; be_b = 2'b11;
        step();
        idle_inputs();
        step();
        rd_port_a(4'd7);
        chk("coll_full", 32'(if0.q_a), 32'h0000AAAA);
        en_a = 1'b1; wr_a = 1'b1; ad_a = 4'd7; d_a = 16'hAAAA; be_a = 2'b01;
        en_b = 1'b1; wr_b = 1'b1; ad_b = 4'd7; d_b = 16'h5555; be_b = 2'b10;
        step();
        idle_inputs();
        step();
        rd_port_a(4'd7);
        chk("coll_split", 32'(if0.q_a), 32'h000055AA);
        step();

        // Cross-port read during write, and write-through
        wr_port_a(4'd2, 16'h0001, 2'b11);
        step();
        step();
        en_a = 1'b1; wr_a = 1'b1; ad_a = 4'd2; d_a = 16'h0002; be_a = 2'b11;
        en_b = 1'b1; wr_b = 1'b0; ad_b = 4'd2;
        step();
        idle_inputs();
        chk("rdw_old_q", 32'(if0.q_b), 32'h00000001);
        chk("rdw_old_v", 32'(if0.valid_b), 32'd1);
        chk("rdw0_q_a", 32'(if0.q_a), 32'h000055AA);
        chk("rdw0_v_a", 32'(if0.valid_a), 32'd0);
        step();
        chk("rdw1_q_a", 32'(if1.q_a), 32'h00000002);
        chk("rdw1_v_a", 32'(if1.valid_a), 32'd1);
        chk("rdw1_q_b", 32'(if1.q_b), 32'h00000001);

        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            en_a = 1'($urandom_range(0, 1));
            wr_a = 1'($urandom_range(0, 1));
            be_a = 2'($urandom_range(0, 3));
            ad_a = 4'($urandom_range(0, 15));
            d_a  = 16'($urandom);
            en_b = 1'($urandom_range(0, 1));
            wr_b = 1'($urandom_range(0, 1));
            be_b = 2'($urandom_range(0, 3));
            ad_b = (($urandom_range(0, 3)) == 0) ? ad_a : 4'($urandom_range(0, 15));
            d_b  = 16'($urandom);
            clr  = ($urandom_range(0, 79) == 0) ? 1'b1 : (clr && ($urandom_range(0, 3) != 0));
            step();
        end
        idle_inputs();
        for (int k = 0; k < 40 && m_busy; k++) step();
        step();
        step();

        // Reset in the middle of a clear
        for (int i = 0; i < int'(DEPTH); i++) wr_port_a(4'(i), 16'h1000 + 16'(i), 2'b11);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_busy", 32'(if0.clear_busy), 32'd0);
        chk("rst_done", 32'(if0.clear_done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_port_b(4'(i));
            chk("part_clr", 32'(if0.q_b), (i < 5) ? 32'(FILL) : 32'h1000 + 32'(i));
        end
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
